// File: rtl/cmd_icd_pkg.sv
// Command-word layout shared by the task parser and cmd_decoder: IDs, field
// positions, a delay-word builder and the decoder FSM state type.
package cmd_icd_pkg;

    typedef enum logic [3:0] {
        CMD_ID_BANK  = 4'b0000,
        CMD_ID_OUT   = 4'b0001,
        CMD_ID_DELAY = 4'b0010
    } cmd_id_t;

    localparam int CMD_ID_LSB = 28;
    localparam int CMD_ID_MSB = 31;

    localparam int BANK_CMD_EN_LSB       = 0;
    localparam int BANK_CMD_EN_MSB       = 3;
    localparam int BANK_CMD_GAP_LSB      = 4;
    localparam int BANK_CMD_GAP_MSB      = 7;
    localparam int BANK_CMD_VAL_LSB      = 8;
    localparam int BANK_CMD_VAL_MSB      = 15;
    localparam int BANK_CMD_RESERVED_LSB = 16;
    localparam int BANK_CMD_RESERVED_MSB = 27;

    localparam int OUT_CMD_SEL_LSB      = 0;
    localparam int OUT_CMD_SEL_MSB      = 4;
    localparam int OUT_CMD_RESERVED_LSB = 5;
    localparam int OUT_CMD_RESERVED_MSB = 27;

    localparam int DELAY_CMD_CNT_LSB      = 0;
    localparam int DELAY_CMD_CNT_MSB      = 15;
    localparam int DELAY_CMD_RESERVED_LSB = 16;
    localparam int DELAY_CMD_RESERVED_MSB = 27;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } cmd_dec_state_t;

    function automatic logic [31:0] task2delay_cmd(input logic [15:0] cnt);
        return {CMD_ID_DELAY, 12'h000, cnt};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with first-word-fall-through head; DEPTH must be a power of two.
module cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cmd_decoder.sv
// Command decoder/executor: buffers 32-bit command words and applies bank, out and
// delay commands in order. Define CMD_DECODER_STRICT_EN to reject malformed words.
module cmd_decoder
    import cmd_icd_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int VAL_W      = 8,
    parameter int OUT_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_data,
    output logic [NUM_BANKS*VAL_W-1:0] bank_val,
    output logic [NUM_BANKS-1:0]       bank_upd,
    output logic [OUT_W-1:0]           out_sel,
    output logic                       out_upd,
    output logic                       err,
    output logic [15:0]                err_cnt,
    output logic                       busy
);
    logic [31:0]    head;
    logic           full, empty, push, pop;
    cmd_id_t        id;
    logic [3:0]     en_f;
    logic [7:0]     val_f;
    logic [4:0]     sel_f;
    logic [15:0]    cnt_f;
    logic           bad;
    logic           do_bank, do_out, do_delay, do_rej;
    cmd_dec_state_t state, state_nxt;
    logic [15:0]    cnt, cnt_nxt;

    // cmd_ready is held low while reset is asserted, not just while full.
    assign cmd_ready = rst_n & ~full;
    assign push      = cmd_valid & cmd_ready;

    cmd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (cmd_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign id    = cmd_id_t'(head[CMD_ID_MSB:CMD_ID_LSB]);
    assign en_f  = head[BANK_CMD_EN_MSB:BANK_CMD_EN_LSB];
    assign val_f = head[BANK_CMD_VAL_MSB:BANK_CMD_VAL_LSB];
    assign sel_f = head[OUT_CMD_SEL_MSB:OUT_CMD_SEL_LSB];
    assign cnt_f = head[DELAY_CMD_CNT_MSB:DELAY_CMD_CNT_LSB];

`ifdef CMD_DECODER_STRICT_EN
    always_comb begin
        bad = 1'b0;
        case (id)
            CMD_ID_BANK:  bad = (|head[BANK_CMD_RESERVED_MSB:BANK_CMD_RESERVED_LSB])
                              | (|head[BANK_CMD_GAP_MSB:BANK_CMD_GAP_LSB])
                              | (|(en_f >> NUM_BANKS)) | (|(val_f >> VAL_W));
            CMD_ID_OUT:   bad = (|head[OUT_CMD_RESERVED_MSB:OUT_CMD_RESERVED_LSB])
                              | (|(sel_f >> OUT_W));
            CMD_ID_DELAY: bad = |head[DELAY_CMD_RESERVED_MSB:DELAY_CMD_RESERVED_LSB];
            default:      bad = 1'b0;
        endcase
    end
`else
    // Reserved and out-of-range bits are deliberately ignored in this build.
    logic unused_fields;
    assign bad           = 1'b0;
    assign unused_fields = ^{head[27:16], head[7:5], en_f, val_f, sel_f};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: if (do_delay) begin
                state_nxt = ST_WAIT;
                cnt_nxt   = cnt_f;
            end
            ST_WAIT: if (cnt == 16'd1) state_nxt = ST_IDLE;
                     else cnt_nxt = cnt - 16'd1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == ST_IDLE) && !empty;
        do_bank  = pop && !bad && (id == CMD_ID_BANK);
        do_out   = pop && !bad && (id == CMD_ID_OUT);
        do_delay = pop && !bad && (id == CMD_ID_DELAY) && (cnt_f != 16'd0);
        do_rej   = pop && (bad || !(id inside {CMD_ID_BANK, CMD_ID_OUT, CMD_ID_DELAY}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_val <= '0;
            bank_upd <= '0;
            out_sel  <= '0;
            out_upd  <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            bank_upd <= '0;
            out_upd  <= do_out;
            err      <= do_rej;
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (do_bank && en_f[i]) begin
                    bank_val[i*VAL_W +: VAL_W] <= val_f[VAL_W-1:0];
                    bank_upd[i]                <= 1'b1;
                end
            end
            if (do_out) out_sel <= sel_f[OUT_W-1:0];
            if (do_rej && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign busy = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder with default parameters; expectations follow
// CMD_DECODER_STRICT_EN when the bench is built with it.
module tb_cmd_decoder;
    localparam int NB = 4;
    localparam int VW = 8;
    localparam int OW = 5;
    localparam int FD = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_data = '0;
    logic [NB*VW-1:0] bank_val;
    logic [NB-1:0]    bank_upd;
    logic [OW-1:0]    out_sel;
    logic             out_upd;
    logic             err;
    logic [15:0]      err_cnt;
    logic             busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_err_cnt = '0;

    cmd_decoder #(.NUM_BANKS(NB), .VAL_W(VW), .OUT_W(OW), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .bank_val  (bank_val),
        .bank_upd  (bank_upd),
        .out_sel   (out_sel),
        .out_upd   (out_upd),
        .err       (err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge, cmd_valid still high.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: cmd_ready=%b required 1 for word %h", cmd_ready, w);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bank_val, bank_upd, out_sel, out_upd, err, err_cnt, busy, cmd_ready} !== '0) begin
            errors++;
            $display("FAIL reset_values: bank_val=%h bank_upd=%b out_sel=%h out_upd=%b err=%b err_cnt=%h busy=%b cmd_ready=%b, required all 0",
                     bank_val, bank_upd, out_sel, out_upd, err, err_cnt, busy, cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_bank_write();
        send(32'h0000_3C0A);
        cmd_valid = 1'b0;
        checks++;
        if (bank_upd !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bank_early: bank_upd=%b busy=%b required 0000/1", bank_upd, busy);
        end
        @(negedge clk);
        checks++;
        if (bank_upd !== 4'b1010 || bank_val !== 32'h3C00_3C00) begin
            errors++;
            $display("FAIL bank_write: bank_upd=%b bank_val=%h required 1010/3c003c00", bank_upd, bank_val);
        end
        @(negedge clk);
        checks++;
        if (bank_upd !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bank_pulse_end: bank_upd=%b busy=%b required 0000/0", bank_upd, busy);
        end
    endtask

    task automatic test_back_to_back();
        send(32'h0000_A505);
        send(32'h0000_0F01);
        cmd_valid = 1'b0;
        checks++;
        if (bank_upd !== 4'b0101 || bank_val !== 32'h3CA5_3CA5) begin
            errors++;
            $display("FAIL b2b_first: bank_upd=%b bank_val=%h required 0101/3ca53ca5", bank_upd, bank_val);
        end
        @(negedge clk);
        checks++;
        if (bank_upd !== 4'b0001 || bank_val !== 32'h3CA5_3C0F) begin
            errors++;
            $display("FAIL b2b_second: bank_upd=%b bank_val=%h required 0001/3ca53c0f", bank_upd, bank_val);
        end
        @(negedge clk);
        checks++;
        if (bank_upd !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_end: bank_upd=%b required 0000", bank_upd);
        end
    endtask

    task automatic test_out_write();
        send(32'h1000_0013);
        cmd_valid = 1'b0;
        checks++;
        if (out_upd !== 1'b0) begin
            errors++;
            $display("FAIL out_early: out_upd=%b required 0", out_upd);
        end
        @(negedge clk);
        checks++;
        if (out_upd !== 1'b1 || out_sel !== 5'h13) begin
            errors++;
            $display("FAIL out_write: out_upd=%b out_sel=%h required 1/13", out_upd, out_sel);
        end
        @(negedge clk);
        checks++;
        if (out_upd !== 1'b0 || out_sel !== 5'h13) begin
            errors++;
            $display("FAIL out_pulse_end: out_upd=%b out_sel=%h required 0/13", out_upd, out_sel);
        end
    endtask

    task automatic test_field_checks();
        logic       exp_err;
        logic       exp_upd;
        logic [4:0] exp_sel;
        // Bank word with enable 0 but bit 4 set.
        send(32'h0000_0110);
        cmd_valid = 1'b0;
        @(negedge clk);
`ifdef CMD_DECODER_STRICT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        if (exp_err) exp_err_cnt = exp_err_cnt + 16'd1;
        checks++;
        if (err !== exp_err || bank_upd !== 4'b0000 || bank_val !== 32'h3CA5_3C0F || err_cnt !== exp_err_cnt) begin
            errors++;
            $display("FAIL bank_reserved: err=%b bank_upd=%b bank_val=%h err_cnt=%h required %b/0000/3ca53c0f/%h",
                     err, bank_upd, bank_val, err_cnt, exp_err, exp_err_cnt);
        end
        // Out word with reserved bits set: truncated in the default build.
        send(32'h1FFF_FFE3);
        cmd_valid = 1'b0;
        @(negedge clk);
`ifdef CMD_DECODER_STRICT_EN
        exp_err = 1'b1;
        exp_upd = 1'b0;
        exp_sel = 5'h13;
`else
        exp_err = 1'b0;
        exp_upd = 1'b1;
        exp_sel = 5'h03;
`endif
        if (exp_err) exp_err_cnt = exp_err_cnt + 16'd1;
        checks++;
        if (err !== exp_err || out_upd !== exp_upd || out_sel !== exp_sel || err_cnt !== exp_err_cnt) begin
            errors++;
            $display("FAIL out_reserved: err=%b out_upd=%b out_sel=%h err_cnt=%h required %b/%b/%h/%h",
                     err, out_upd, out_sel, err_cnt, exp_err, exp_upd, exp_sel, exp_err_cnt);
        end
        // Enable 0 is a silent no-op.
        send(32'h0000_FF00);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || bank_upd !== 4'b0000 || bank_val !== 32'h3CA5_3C0F) begin
            errors++;
            $display("FAIL enable_zero: err=%b bank_upd=%b bank_val=%h required 0/0000/3ca53c0f", err, bank_upd, bank_val);
        end
    endtask

    task automatic test_delay();
        // Zero-count delay does not stall the following word.
        send(32'h2000_0000);
        send(32'h1000_0002);
        cmd_valid = 1'b0;
        checks++;
        if (out_upd !== 1'b0) begin
            errors++;
            $display("FAIL delay0_early: out_upd=%b required 0", out_upd);
        end
        @(negedge clk);
        checks++;
        if (out_upd !== 1'b1 || out_sel !== 5'h02) begin
            errors++;
            $display("FAIL delay0_next: out_upd=%b out_sel=%h required 1/02", out_upd, out_sel);
        end
        @(negedge clk);
        // Delay of 5: the out word's pulse appears 6 cycles after the delay word is popped.
        send(32'h2000_0005);
        send(32'h1000_0001);
        cmd_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (out_upd !== (j == 6)) begin
                errors++;
                $display("FAIL delay5_cycle%0d: out_upd=%b required %b", j, out_upd, (j == 6));
            end
            if (j == 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL delay5_busy: busy=%b required 1", busy);
                end
            end
            if (j < 6) @(negedge clk);
        end
        checks++;
        if (out_sel !== 5'h01) begin
            errors++;
            $display("FAIL delay5_sel: out_sel=%h required 01", out_sel);
        end
        @(negedge clk);
    endtask

    task automatic test_reject();
        send(32'h3000_0000);
        send(32'hF123_4567);
        cmd_valid = 1'b0;
        exp_err_cnt = exp_err_cnt + 16'd1;
        checks++;
        if (err !== 1'b1 || err_cnt !== exp_err_cnt || bank_upd !== 4'b0000 || out_upd !== 1'b0) begin
            errors++;
            $display("FAIL reject_first: err=%b err_cnt=%h bank_upd=%b out_upd=%b required 1/%h/0000/0",
                     err, err_cnt, bank_upd, out_upd, exp_err_cnt);
        end
        @(negedge clk);
        exp_err_cnt = exp_err_cnt + 16'd1;
        checks++;
        if (err !== 1'b1 || err_cnt !== exp_err_cnt) begin
            errors++;
            $display("FAIL reject_second: err=%b err_cnt=%h required 1/%h", err, err_cnt, exp_err_cnt);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || err_cnt !== exp_err_cnt || bank_val !== 32'h3CA5_3C0F || out_sel !== 5'h01) begin
            errors++;
            $display("FAIL reject_after: err=%b err_cnt=%h bank_val=%h out_sel=%h required 0/%h/3ca53c0f/01",
                     err, err_cnt, bank_val, out_sel, exp_err_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [5];
        logic [4:0]  exp_q [$];
        logic [4:0]  exp;
        int          idx;
        bit          drop_checked;
        idx = 0;
        drop_checked = 0;
        for (int k = 0; k < 5; k++) begin
            words[k] = 32'h1000_0004 + 32'(k);
            exp_q.push_back(5'(4 + k));
        end
        send(32'h2000_0010);
        for (int cyc = 0; cyc < 80 && (idx < 5 || exp_q.size() != 0); cyc++) begin
            if (out_upd === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_pulse: out_sel=%h with no word pending", out_sel);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_sel !== exp) begin
                        errors++;
                        $display("FAIL bp_order: out_sel=%h required %h", out_sel, exp);
                    end
                end
            end
            if (idx == FD && !drop_checked) begin
                drop_checked = 1;
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_drop: cmd_ready=%b required 0 after %0d accepts", cmd_ready, FD);
                end
            end
            if (idx < 5) begin
                cmd_valid = 1'b1;
                cmd_data  = words[idx];
                if (cmd_ready === 1'b1) idx++;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (idx != 5 || exp_q.size() != 0 || !drop_checked) begin
            errors++;
            $display("FAIL bp_complete: accepted=%0d pending=%0d drop_seen=%0d required 5/0/1", idx, exp_q.size(), drop_checked);
        end
    endtask

    task automatic test_reset_mid_wait();
        int idx;
        idx = 0;
        send(32'h2000_0100);
        for (int cyc = 0; cyc < 20 && idx < FD; cyc++) begin
            cmd_data = 32'h0000_FF0F;
            if (cmd_ready === 1'b1) idx++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midwait_full: busy=%b cmd_ready=%b required 1/0", busy, cmd_ready);
        end
        rst_n = 1'b0;
        #1;
        exp_err_cnt = '0;
        checks++;
        if ({bank_val, bank_upd, out_sel, out_upd, err, err_cnt, busy, cmd_ready} !== '0) begin
            errors++;
            $display("FAIL midwait_reset: bank_val=%h bank_upd=%b out_sel=%h out_upd=%b err=%b err_cnt=%h busy=%b cmd_ready=%b, required all 0",
                     bank_val, bank_upd, out_sel, out_upd, err, err_cnt, busy, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({bank_val, bank_upd, out_sel, out_upd, err, err_cnt, busy} !== '0) begin
                errors++;
                $display("FAIL midwait_discard_c%0d: bank_val=%h bank_upd=%b out_sel=%h out_upd=%b err=%b err_cnt=%h busy=%b, required all 0",
                         c, bank_val, bank_upd, out_sel, out_upd, err, err_cnt, busy);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_bank_write();
        test_back_to_back();
        test_out_write();
        test_field_checks();
        test_delay();
        test_reject();
        test_backpressure();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
